ponylink_stream_checker: RTL and testbench

- Receive-side stream sink and checker for the master end of a ponylink link.
- Connects to the master's out_* AXI-stream port and consumes the beats the slave sends.
- Checks packet length, tdata/tuser content and framing, and exposes sticky error flags and saturating counters.
- Used in simulation and formal harnesses as the counterpart to a slave-side stream source.

---
 rtl/ponylink_stream_checker.sv | 232 +++++++++++++++++++++++
 tb/tb_ponylink_stream_checker.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ponylink_stream_checker.sv
// ============================================================================
// Module   : ponylink_stream_checker
// Purpose  : Receive-side stream sink and checker for the master end of a
//            ponylink link. Consumes the out_* AXI-stream beats sent by the
//            slave, checks packet length and tdata/tuser content, and reports
//            sticky error flags plus saturating counters.
// Ports    : clk          - clock, rising edge
//            resetn       - asynchronous active-low reset
//            linkready    - link-up indication from the ponylink master
//            s_tdata      - stream data          (TDATA_WIDTH)
//            s_tuser      - stream sideband      (TUSER_WIDTH)
//            s_tvalid     - stream valid
//            s_tlast      - end of packet
//            s_tready     - stream ready (linkready delayed one cycle)
//            pkt_count    - legal-length packets completed, saturating
//            beat_count   - accepted beats, saturating
//            abort_count  - packets cut short by linkready falling, saturating
//            len_error    - sticky: packet too long or too short
//            data_error   - sticky: tdata or tuser mismatch
//            busy         - high while inside a packet
// Options  : PONYLINK_CHECKER_THROTTLE_EN - when defined, a 16-bit LFSR
//            randomly deasserts s_tready (~25% of cycles) for backpressure.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ponylink_stream_checker #(
  parameter int                     TDATA_WIDTH = 8,
  parameter int                     TUSER_WIDTH = 4,
  parameter int                     MAX_LEN     = 32,
  parameter int                     MIN_LEN     = 1,
  parameter int                     DATA_MODE   = 0,
  parameter logic [TDATA_WIDTH-1:0] EXP_TDATA   = '0,
  parameter logic [TUSER_WIDTH-1:0] EXP_TUSER   = '0,
  parameter int                     CNT_WIDTH   = 16
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   linkready,
  input  logic [TDATA_WIDTH-1:0] s_tdata,
  input  logic [TUSER_WIDTH-1:0] s_tuser,
  input  logic                   s_tvalid,
  input  logic                   s_tlast,
  output logic                   s_tready,
  output logic [CNT_WIDTH-1:0]   pkt_count,
  output logic [CNT_WIDTH-1:0]   beat_count,
  output logic [CNT_WIDTH-1:0]   abort_count,
  output logic                   len_error,
  output logic                   data_error,
  output logic                   busy
);

  // One spare bit so the overrun index MAX_LEN+1 is always representable.
  localparam int                     IDX_W       = $clog2(MAX_LEN + 1) + 1;
  localparam logic [IDX_W-1:0]       C_IDX_ONE   = IDX_W'(1);
  localparam logic [IDX_W-1:0]       C_IDX_MAX   = IDX_W'(MAX_LEN);
  localparam logic [IDX_W-1:0]       C_IDX_MIN   = IDX_W'(MIN_LEN);
  localparam logic [CNT_WIDTH-1:0]   C_CNT_ONE   = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0]   C_CNT_MAX   = '1;
  localparam logic [TDATA_WIDTH-1:0] C_DATA_ONE  = TDATA_WIDTH'(1);

  typedef enum logic [0:0] {
    S_IDLE   = 1'b0,
    S_IN_PKT = 1'b1
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [IDX_W-1:0]       r_idx;
  logic [IDX_W-1:0]       w_idx_nxt;
  logic [IDX_W-1:0]       w_idx_beat;
  logic [TDATA_WIDTH-1:0] r_exp;
  logic [TDATA_WIDTH-1:0] w_exp_cur;
  logic [CNT_WIDTH-1:0]   r_pkt_cnt;
  logic [CNT_WIDTH-1:0]   r_beat_cnt;
  logic [CNT_WIDTH-1:0]   r_abort_cnt;
  logic                   r_len_err;
  logic                   r_data_err;
  logic                   r_link_q;
  logic                   w_acc;
  logic                   w_len_ok;
  logic                   w_data_bad;
  logic                   w_pkt_inc;
  logic                   w_len_set;
  logic                   w_abort;

  // --------------------------------------------------------------------------
  // Ready generation
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_link_q <= 1'b0;
    end else begin
      r_link_q <= linkready;
    end
  end

`ifdef PONYLINK_CHECKER_THROTTLE_EN
  logic [15:0] r_lfsr;

  // Fibonacci LFSR, taps 16,14,13,11.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_lfsr <= 16'hACE1;
    end else begin
      r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
    end
  end

  assign s_tready = r_link_q && (r_lfsr[1:0] != 2'b00);
`else
  assign s_tready = r_link_q;
`endif

  // --------------------------------------------------------------------------
  // Per-beat datapath
  // --------------------------------------------------------------------------
  always_comb begin
    w_acc      = s_tvalid && s_tready;
    // A beat taken in IDLE is always the first beat of a fresh packet.
    w_idx_beat = (r_state == S_IDLE) ? C_IDX_ONE : (r_idx + C_IDX_ONE);
    w_exp_cur  = (r_state == S_IDLE) ? EXP_TDATA : r_exp;
    w_len_ok   = (w_idx_beat >= C_IDX_MIN) && (w_idx_beat <= C_IDX_MAX);
    w_data_bad = (s_tuser != EXP_TUSER);
    if (DATA_MODE == 0) begin
      w_data_bad = w_data_bad || (s_tdata != EXP_TDATA);
    end else if (DATA_MODE == 1) begin
      w_data_bad = w_data_bad || (s_tdata != w_exp_cur);
    end
  end

  // --------------------------------------------------------------------------
  // Packet FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_pkt_inc   = 1'b0;
    w_len_set   = 1'b0;
    w_abort     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_acc) begin
          w_idx_nxt = w_idx_beat;
          if (s_tlast) begin
            w_pkt_inc = w_len_ok;
            w_len_set = !w_len_ok;
          end else begin
            w_state_nxt = S_IN_PKT;
          end
        end
      end
      S_IN_PKT: begin
        if (!linkready) begin
          // Link dropped: abandon the packet; a beat in this cycle is still
          // counted and data-checked but never length-checked.
          w_abort     = 1'b1;
          w_state_nxt = S_IDLE;
          w_idx_nxt   = '0;
        end else if (w_acc) begin
          w_idx_nxt = w_idx_beat;
          if (s_tlast) begin
            w_pkt_inc   = w_len_ok;
            w_len_set   = !w_len_ok;
            w_state_nxt = S_IDLE;
          end else if (w_idx_beat > C_IDX_MAX) begin
            // Overrun: flag it and resynchronise on the next beat.
            w_len_set   = 1'b1;
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_idx_nxt   = '0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Expected data, counters and sticky flags
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_exp       <= '0;
      r_pkt_cnt   <= '0;
      r_beat_cnt  <= '0;
      r_abort_cnt <= '0;
      r_len_err   <= 1'b0;
      r_data_err  <= 1'b0;
    end else begin
      if (w_acc) begin
        r_exp <= w_exp_cur + C_DATA_ONE;
        if (r_beat_cnt != C_CNT_MAX) begin
          r_beat_cnt <= r_beat_cnt + C_CNT_ONE;
        end
        if (w_data_bad) begin
          r_data_err <= 1'b1;
        end
      end
      if (w_pkt_inc && (r_pkt_cnt != C_CNT_MAX)) begin
        r_pkt_cnt <= r_pkt_cnt + C_CNT_ONE;
      end
      if (w_abort && (r_abort_cnt != C_CNT_MAX)) begin
        r_abort_cnt <= r_abort_cnt + C_CNT_ONE;
      end
      if (w_len_set) begin
        r_len_err <= 1'b1;
      end
    end
  end

  assign pkt_count   = r_pkt_cnt;
  assign beat_count  = r_beat_cnt;
  assign abort_count = r_abort_cnt;
  assign len_error   = r_len_err;
  assign data_error  = r_data_err;
  assign busy        = (r_state == S_IN_PKT);

endmodule

`default_nettype wire

// File: tb/tb_ponylink_stream_checker.sv
// ============================================================================
// Module   : tb_ponylink_stream_checker
// Purpose  : Self-checking bench. Two checker instances share one stream:
//            A = defaults (constant data 0, lengths 1..32, 16-bit counters),
//            B = incrementing data from 8'hFE, tuser 3, lengths 2..8,
//                4-bit counters (so saturation is reached).
//            Both are compared against a packet-level reference model every
//            cycle; directed tables and sequences cover the corner cases.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ponylink_stream_checker;

  logic       clk = 1'b0;
  logic       resetn;
  logic       linkready;
  logic [7:0] s_tdata;
  logic [3:0] s_tuser;
  logic       s_tvalid;
  logic       s_tlast;

  logic        a_rdy, a_lerr, a_derr, a_busy;
  logic [15:0] a_pkt, a_beat, a_abort;
  logic        b_rdy, b_lerr, b_derr, b_busy;
  logic [3:0]  b_pkt, b_beat, b_abort;

  always #5 clk = ~clk;

  ponylink_stream_checker #(
    .TDATA_WIDTH(8), .TUSER_WIDTH(4), .MAX_LEN(32), .MIN_LEN(1),
    .DATA_MODE(0), .EXP_TDATA(8'h00), .EXP_TUSER(4'h0), .CNT_WIDTH(16)
  ) u_a (
    .clk(clk), .resetn(resetn), .linkready(linkready),
    .s_tdata(s_tdata), .s_tuser(s_tuser), .s_tvalid(s_tvalid), .s_tlast(s_tlast),
    .s_tready(a_rdy), .pkt_count(a_pkt), .beat_count(a_beat), .abort_count(a_abort),
    .len_error(a_lerr), .data_error(a_derr), .busy(a_busy)
  );

  ponylink_stream_checker #(
    .TDATA_WIDTH(8), .TUSER_WIDTH(4), .MAX_LEN(8), .MIN_LEN(2),
    .DATA_MODE(1), .EXP_TDATA(8'hFE), .EXP_TUSER(4'h3), .CNT_WIDTH(4)
  ) u_b (
    .clk(clk), .resetn(resetn), .linkready(linkready),
    .s_tdata(s_tdata), .s_tuser(s_tuser), .s_tvalid(s_tvalid), .s_tlast(s_tlast),
    .s_tready(b_rdy), .pkt_count(b_pkt), .beat_count(b_beat), .abort_count(b_abort),
    .len_error(b_lerr), .data_error(b_derr), .busy(b_busy)
  );

  // ---------------- bookkeeping ----------------
  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int c_min [2] = '{1, 2};
  int c_max [2] = '{32, 8};
  int c_mode[2] = '{0, 1};
  int c_exp [2] = '{8'h00, 8'hFE};
  int c_etu [2] = '{4'h0, 4'h3};
  int c_sat [2] = '{65535, 15};

  int   m_len[2], m_pkt[2], m_beat[2], m_abort[2];
  bit   m_lerr[2], m_derr[2];
  bit   m_rdy, m_link;
  logic [15:0] m_lfsr;

  function automatic int sat(input int v, input int k);
    return (v >= c_sat[k]) ? c_sat[k] : v + 1;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_len[k] = 0; m_pkt[k] = 0; m_beat[k] = 0; m_abort[k] = 0;
      m_lerr[k] = 1'b0; m_derr[k] = 1'b0;
    end
    m_rdy  = 1'b0;
    m_link = 1'b0;
    m_lfsr = 16'hACE1;
  endtask

  // Applies one clock edge worth of the stream rules, using the inputs that
  // were stable before the edge. m_len = beats already taken in the packet.
  task automatic model_step();
    bit         acc;
    int         n;
    logic [7:0] e;
    acc = s_tvalid && m_rdy;
    for (int k = 0; k < 2; k++) begin
      if (acc) begin
        m_beat[k] = sat(m_beat[k], k);
        e = (c_mode[k] == 1) ? 8'(c_exp[k] + m_len[k]) : 8'(c_exp[k]);
        if (s_tuser != 4'(c_etu[k]) || (c_mode[k] != 2 && s_tdata != e))
          m_derr[k] = 1'b1;
      end
      if (m_len[k] > 0 && !linkready) begin
        m_abort[k] = sat(m_abort[k], k);
        m_len[k]   = 0;
      end else if (acc) begin
        n = m_len[k] + 1;
        if (s_tlast) begin
          if (n < c_min[k] || n > c_max[k]) m_lerr[k] = 1'b1;
          else                              m_pkt[k]  = sat(m_pkt[k], k);
          m_len[k] = 0;
        end else if (n > c_max[k]) begin
          m_lerr[k] = 1'b1;
          m_len[k]  = 0;
        end else begin
          m_len[k] = n;
        end
      end
    end
`ifdef PONYLINK_CHECKER_THROTTLE_EN
    m_link = linkready;
    m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    m_rdy  = m_link && (m_lfsr[1:0] != 2'b00);
`else
    m_rdy  = linkready;
`endif
  endtask

  task automatic compare_all();
    check("a_tready", a_rdy,   m_rdy);
    check("a_pkt",    a_pkt,   m_pkt[0]);
    check("a_beat",   a_beat,  m_beat[0]);
    check("a_abort",  a_abort, m_abort[0]);
    check("a_lerr",   a_lerr,  m_lerr[0]);
    check("a_derr",   a_derr,  m_derr[0]);
    check("a_busy",   a_busy,  m_len[0] > 0);
    check("b_tready", b_rdy,   m_rdy);
    check("b_pkt",    b_pkt,   m_pkt[1]);
    check("b_beat",   b_beat,  m_beat[1]);
    check("b_abort",  b_abort, m_abort[1]);
    check("b_lerr",   b_lerr,  m_lerr[1]);
    check("b_derr",   b_derr,  m_derr[1]);
    check("b_busy",   b_busy,  m_len[1] > 0);
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic drive(input bit lr, input bit v, input logic [7:0] d,
                       input logic [3:0] u, input bit l);
    linkready = lr; s_tvalid = v; s_tdata = d; s_tuser = u; s_tlast = l;
  endtask

  task automatic step();
    @(posedge clk);
    if (resetn) model_step();
    else        model_reset();
    #1;
    compare_all();
  endtask

  // Asserts reset off the clock edge and checks outputs before any edge.
  task automatic do_reset();
    resetn = 1'b0;
    drive(1'b0, 1'b0, 8'h00, 4'h0, 1'b0);
    model_reset();
    #1;
    compare_all();
    @(posedge clk);
    #1;
    resetn = 1'b1;
  endtask

  task automatic send_pkt(input int len, input logic [7:0] start, input bit incr,
                          input logic [3:0] u);
    for (int i = 0; i < len; i++) begin
      drive(1'b1, 1'b1, incr ? 8'(start + i) : start, u, i == len - 1);
      step();
    end
    drive(1'b1, 1'b0, 8'h00, 4'h0, 1'b0);
  endtask

  // ---------------- directed vector table (checker A) ----------------
  typedef struct {
    bit lr; bit v; logic [7:0] d; logic [3:0] u; bit l;
    int pkt; int beat; int abrt; bit lerr; bit derr; bit busy; bit rdy;
  } vec_t;

  vec_t tbl[14];

  initial begin
    resetn = 1'b1;
    drive(1'b0, 1'b0, 8'h00, 4'h0, 1'b0);
    #2;

`ifndef PONYLINK_CHECKER_THROTTLE_EN
    //           lr v  d     u     l   pkt beat ab le de busy rdy
    tbl[0]  = '{1, 0, 8'h00, 4'h0, 0,  0,  0,  0, 0, 0, 0, 1};
    tbl[1]  = '{1, 1, 8'h00, 4'h0, 0,  0,  1,  0, 0, 0, 1, 1};
    tbl[2]  = '{1, 1, 8'h00, 4'h0, 1,  1,  2,  0, 0, 0, 0, 1};
    tbl[3]  = '{1, 1, 8'h00, 4'h0, 1,  2,  3,  0, 0, 0, 0, 1};
    tbl[4]  = '{1, 1, 8'h05, 4'h0, 0,  2,  4,  0, 0, 1, 1, 1};
    tbl[5]  = '{1, 0, 8'h00, 4'h0, 0,  2,  4,  0, 0, 1, 1, 1};
    tbl[6]  = '{1, 1, 8'h00, 4'h1, 1,  3,  5,  0, 0, 1, 0, 1};
    tbl[7]  = '{0, 1, 8'h00, 4'h0, 0,  3,  6,  0, 0, 1, 1, 0};
    tbl[8]  = '{1, 1, 8'h00, 4'h0, 1,  3,  6,  0, 0, 1, 1, 1};
    tbl[9]  = '{1, 1, 8'h00, 4'h0, 1,  4,  7,  0, 0, 1, 0, 1};
    tbl[10] = '{1, 1, 8'h00, 4'h0, 0,  4,  8,  0, 0, 1, 1, 1};
    tbl[11] = '{0, 0, 8'h00, 4'h0, 0,  4,  8,  1, 0, 1, 0, 0};
    tbl[12] = '{1, 1, 8'h00, 4'h0, 1,  4,  8,  1, 0, 1, 0, 1};
    tbl[13] = '{1, 1, 8'h00, 4'h0, 1,  5,  9,  1, 0, 1, 0, 1};

    do_reset();
    for (int i = 0; i < 14; i++) begin
      drive(tbl[i].lr, tbl[i].v, tbl[i].d, tbl[i].u, tbl[i].l);
      step();
      check($sformatf("tbl%0d_pkt", i),   a_pkt,   tbl[i].pkt);
      check($sformatf("tbl%0d_beat", i),  a_beat,  tbl[i].beat);
      check($sformatf("tbl%0d_abort", i), a_abort, tbl[i].abrt);
      check($sformatf("tbl%0d_lerr", i),  a_lerr,  tbl[i].lerr);
      check($sformatf("tbl%0d_derr", i),  a_derr,  tbl[i].derr);
      check($sformatf("tbl%0d_busy", i),  a_busy,  tbl[i].busy);
      check($sformatf("tbl%0d_rdy", i),   a_rdy,   tbl[i].rdy);
    end

    // Ten 4-beat packets of zeros.
    do_reset();
    drive(1'b1, 1'b0, 8'h00, 4'h0, 1'b0);
    step();
    for (int p = 0; p < 10; p++) send_pkt(4, 8'h00, 1'b0, 4'h0);
    check("s1_pkt",  a_pkt,  10);
    check("s1_beat", a_beat, 40);
    check("s1_lerr", a_lerr, 0);
    check("s1_derr", a_derr, 0);

    // tlast stuck low: overrun on beat 33.
    do_reset();
    drive(1'b1, 1'b0, 8'h00, 4'h0, 1'b0);
    step();
    for (int i = 1; i <= 33; i++) begin
      drive(1'b1, 1'b1, 8'h00, 4'h0, 1'b0);
      step();
      if (i == 32) check("ovr_lerr_b32", a_lerr, 0);
    end
    check("ovr_lerr_b33", a_lerr, 1);
    check("ovr_busy",     a_busy, 0);
    check("ovr_pkt",      a_pkt,  0);
    check("ovr_derr",     a_derr, 0);

    // Incrementing data wraps FE,FF,00; then a bad second beat.
    do_reset();
    drive(1'b1, 1'b0, 8'h00, 4'h3, 1'b0);
    step();
    send_pkt(3, 8'hFE, 1'b1, 4'h3);
    check("inc_derr_ok", b_derr, 0);
    check("inc_pkt",     b_pkt,  1);
    drive(1'b1, 1'b1, 8'hFE, 4'h3, 1'b0);
    step();
    check("inc_derr_b1", b_derr, 0);
    drive(1'b1, 1'b1, 8'h00, 4'h3, 1'b1);
    step();
    check("inc_derr_b2", b_derr, 1);

    // Single-beat packet below MIN_LEN=2.
    do_reset();
    drive(1'b1, 1'b0, 8'h00, 4'h3, 1'b0);
    step();
    drive(1'b1, 1'b1, 8'hFE, 4'h3, 1'b1);
    step();
    check("short_lerr", b_lerr, 1);
    check("short_pkt",  b_pkt,  0);
    check("short_busy", b_busy, 0);

    // Abort at idx=5, then a full packet.
    do_reset();
    drive(1'b1, 1'b0, 8'h00, 4'h0, 1'b0);
    step();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b1, 8'h00, 4'h0, 1'b0);
      step();
    end
    check("abt_busy_pre", a_busy, 1);
    drive(1'b0, 1'b0, 8'h00, 4'h0, 1'b0);
    step();
    check("abt_count", a_abort, 1);
    check("abt_rdy",   a_rdy,   0);
    check("abt_busy",  a_busy,  0);
    drive(1'b1, 1'b0, 8'h00, 4'h0, 1'b0);
    step();
    send_pkt(3, 8'h00, 1'b0, 4'h0);
    check("abt_pkt_after", a_pkt, 1);

    // Asynchronous reset mid-packet (do_reset checks before any edge).
    send_pkt(2, 8'h00, 1'b0, 4'h0);
    drive(1'b1, 1'b1, 8'h00, 4'h0, 1'b0);
    step();
    check("ares_busy_pre", a_busy, 1);
    do_reset();
    check("ares_busy", a_busy, 0);
    check("ares_beat", a_beat, 0);
`endif

    // Randomized episodes against the model.
    for (int ep = 0; ep < 4; ep++) begin
      do_reset();
      for (int c = 0; c < 300; c++) begin
        int r;
        r = $urandom_range(0, 9);
        linkready = ($urandom_range(0, 9) != 0);
        s_tvalid  = ($urandom_range(0, 2) != 0);
        s_tlast   = (ep % 2 == 1) ? ($urandom_range(0, 19) == 0) : ($urandom_range(0, 3) == 0);
        s_tuser   = (r < 6) ? 4'h3 : (r < 9) ? 4'h0 : 4'($urandom);
        r = $urandom_range(0, 9);
        s_tdata   = (r < 3) ? 8'h00 : (r < 8) ? 8'(8'hFE + m_len[1]) : 8'($urandom);
        step();
      end
    end

`ifdef PONYLINK_CHECKER_THROTTLE_EN
    // Backpressure rate over 1000 cycles of continuous valid.
    do_reset();
    for (int i = 0; i < 1000; i++) begin
      drive(1'b1, 1'b1, 8'h00, 4'h0, (i % 4) == 3);
      step();
    end
    checks++;
    if (a_beat < 650 || a_beat > 850) begin
      errors++;
      $display("FAIL throttle_rate: got %0d accepted beats, expected 650..850", a_beat);
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
